gfx_cmd_unit: RTL

GFX_CMD_UNIT -- requirements
Module: gfx_cmd_unit

---
 rtl/gfx_pkg.sv | 41 ++++
 rtl/gfx_cmd_unit_if.sv | 32 +++
 rtl/gfx_addr_gen.sv | 19 +
 rtl/gfx_cmd_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared types for the graphics command unit: opcodes, FSM states,
// the 8-entry RGB332 palette and the colour-word decoder.
package gfx_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_PIXEL = 3'd1,
        OP_RECT  = 3'd2,
        OP_FILL  = 3'd3,
        OP_SWAP  = 3'd6
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PIXEL,
        S_RECT,
        S_SWAP_WAIT,
        S_DONE
    } state_e;

    // Entry i lives in bits [8*i +: 8].
    localparam logic [63:0] PALETTE = {
        8'h1F, 8'hE3, 8'hFC, 8'hFF,
        8'h00, 8'h03, 8'h1C, 8'hE0
    };

    // bit11: immediate word, bit7: raw byte, else palette index [2:0].
    // The caller truncates to its pixel width.
    function automatic logic [15:0] color_word(input logic [15:0] c);
        logic [2:0] idx;
        idx = c[2:0];
        if (c[11]) begin
            return c;
        end
        if (c[7]) begin
            return {8'h00, c[7:0]};
        end
        return {8'h00, PALETTE[{idx, 3'b000} +: 8]};
    endfunction

endpackage

// File: rtl/gfx_cmd_unit_if.sv
// Command channel and framebuffer write port of the graphics unit.
// slave = the command unit, master = command source / framebuffer.
interface gfx_cmd_unit_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 15
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [15:0]       cmd_x;
    logic [15:0]       cmd_y;
    logic [15:0]       cmd_w;
    logic [15:0]       cmd_h;
    logic [15:0]       cmd_color;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              wr_buf;
    logic              wr_ready;

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y,
        input  cmd_w, cmd_h, cmd_color, wr_ready,
        output cmd_ready, wr_en, wr_addr, wr_data, wr_buf
    );

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y,
        output cmd_w, cmd_h, cmd_color, wr_ready,
        input  cmd_ready, wr_en, wr_addr, wr_data, wr_buf
    );
endinterface

// File: rtl/gfx_addr_gen.sv
// Maps a pixel coordinate to its linear framebuffer address and
// reports whether that pixel may be written (always, unless clipping).
module gfx_addr_gen #(
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int ADDR_W = 15,
    parameter bit CLIP   = 1'b0
) (
    input  logic [16:0]       x,
    input  logic [16:0]       y,
    output logic [ADDR_W-1:0] addr,
    output logic              ok
);
    // Wide product so the largest coordinates cannot overflow.
    always_comb begin
        addr = ADDR_W'((34'(y) * 34'(FB_W)) + 34'(x));
        ok   = CLIP ? ((x < 17'(FB_W)) && (y < 17'(FB_H))) : 1'b1;
    end
endmodule

// File: rtl/gfx_cmd_unit.sv
// Graphics command unit: PIXEL/RECT/FILL rasteriser and buffer swap.
// Define GFX_CLIP_EN to suppress writes outside the framebuffer.
module gfx_cmd_unit
    import gfx_pkg::*;
#(
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 15
) (
    input  logic          Clk,
    input  logic          Reset_al,
    gfx_cmd_unit_if.slave bus,
    input  logic          vblank,
    output logic          disp_buf,
    output logic          busy,
    output logic          done
);
`ifdef GFX_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    state_e            state;
    logic              ready;
    logic              wr_en;
    logic              work;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic [15:0]       x0, y0, w, h, col, row;
    logic [15:0]       ncol, nrow, sx, sy, sw, sh;
    logic [16:0]       px, py;
    logic [ADDR_W-1:0] addr;
    logic              pix_ok;
    logic              last;
    logic              adv;
    logic              is_fill;
    logic              is_pix;

    assign bus.cmd_ready = ready;
    assign bus.wr_en     = wr_en;
    assign bus.wr_addr   = wr_addr;
    assign bus.wr_data   = wr_data;
    assign bus.wr_buf    = work;
    assign disp_buf      = ~work;

    // Coordinate of the pixel to present next: the command origin while
    // idle, otherwise the raster successor of the current pixel.
    always_comb begin
        is_fill = (bus.cmd_op == OP_FILL);
        is_pix  = (bus.cmd_op == OP_PIXEL);
        sx = is_fill ? 16'd0 : bus.cmd_x;
        sy = is_fill ? 16'd0 : bus.cmd_y;
        sw = is_fill ? 16'(FB_W) : (is_pix ? 16'd1 : bus.cmd_w);
        sh = is_fill ? 16'(FB_H) : (is_pix ? 16'd1 : bus.cmd_h);
        last = (col == w - 16'd1) && (row == h - 16'd1);
        if (col == w - 16'd1) begin
            ncol = 16'd0;
            nrow = row + 16'd1;
        end else begin
            ncol = col + 16'd1;
            nrow = row;
        end
        if (state == S_IDLE) begin
            px = {1'b0, sx};
            py = {1'b0, sy};
        end else begin
            px = {1'b0, x0} + {1'b0, ncol};
            py = {1'b0, y0} + {1'b0, nrow};
        end
        adv = ~wr_en | bus.wr_ready;
    end

    gfx_addr_gen #(
        .FB_W   (FB_W),
        .FB_H   (FB_H),
        .ADDR_W (ADDR_W),
        .CLIP   (CLIP_EN)
    ) u_addr_gen (
        .x    (px),
        .y    (py),
        .addr (addr),
        .ok   (pix_ok)
    );

    // Command FSM with registered handshake, write port and status.
    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al) begin
            state   <= S_IDLE;
            ready   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            work    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            x0      <= '0;
            y0      <= '0;
            w       <= '0;
            h       <= '0;
            col     <= '0;
            row     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (ready && bus.cmd_valid) begin
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        x0      <= sx;
                        y0      <= sy;
                        w       <= sw;
                        h       <= sh;
                        col     <= '0;
                        row     <= '0;
                        wr_addr <= addr;
                        wr_data <= PIX_W'(color_word(bus.cmd_color));
                        case (bus.cmd_op)
                            OP_PIXEL: begin
                                state <= S_PIXEL;
                                wr_en <= pix_ok;
                            end
                            OP_RECT, OP_FILL: begin
                                if (sw == 16'd0 || sh == 16'd0) begin
                                    state <= S_DONE;
                                    done  <= 1'b1;
                                end else begin
                                    state <= S_RECT;
                                    wr_en <= pix_ok;
                                end
                            end
                            OP_SWAP: state <= S_SWAP_WAIT;
                            default: begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
                        endcase
                    end else begin
                        ready <= 1'b1;
                    end
                end
                S_PIXEL, S_RECT: begin
                    if (adv) begin
                        if (last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            wr_en <= 1'b0;
                        end else begin
                            col     <= ncol;
                            row     <= nrow;
                            wr_addr <= addr;
                            wr_en   <= pix_ok;
                        end
                    end
                end
                S_SWAP_WAIT: begin
                    if (vblank) begin
                        work  <= ~work;
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
